mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-port memory arbiter for CPU fetch/load/store and an external master
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   i_read_*  / d_read_*          CPU fetch / load request level, size (w, hw, else byte), address
//   d_write_*                     CPU store request level, size, address, lane-aligned data
//   read_valid, read_data         CPU read completion pulse and data (data held to next CPU read)
//   write_finish                  CPU store completion pulse
//   e_req, e_we, e_w, e_hw,       external master request level, write flag, size,
//   e_adr, e_wdata                address and write data
//   e_done, e_rdata               external completion pulse and read data
//   bus_err                       pulses with the completion pulse when the access timed out
//   m_req, m_we, m_adr, m_wdata,  single-cycle command to the memory controller
//   m_be
//   m_ack, m_rdata                memory completion strobe and same-cycle read data
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read_req,
    input  logic        i_read_w,
    input  logic        i_read_hw,
    input  logic [31:0] i_read_adr,
    input  logic        d_read_req,
    input  logic        d_read_w,
    input  logic        d_read_hw,
    input  logic [31:0] d_read_adr,
    input  logic        d_write_req,
    input  logic        d_write_w,
    input  logic        d_write_hw,
    input  logic [31:0] d_write_adr,
    input  logic [31:0] d_write_data,
    output logic        read_valid,
    output logic [31:0] read_data,
    output logic        write_finish,
    input  logic        e_req,
    input  logic        e_we,
    input  logic        e_w,
    input  logic        e_hw,
    input  logic [31:0] e_adr,
    input  logic [31:0] e_wdata,
    output logic        e_done,
    output logic [31:0] e_rdata,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0]  ID_IREAD    = 2'd0;
    localparam logic [1:0]  ID_DREAD    = 2'd1;
    localparam logic [1:0]  ID_DWRITE   = 2'd2;
    localparam logic [1:0]  ID_EXT      = 2'd3;
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    function automatic logic [3:0] byte_en(input logic w, input logic hw, input logic [1:0] a);
        if (w) begin
            return 4'b1111;
        end else if (hw) begin
            return a[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b0001 << a;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  id_q, id_d;
    logic        last_ext_q, last_ext_d;
    logic [15:0] cnt_q, cnt_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_adr_q, m_adr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic        read_valid_q, read_valid_d;
    logic [31:0] read_data_q, read_data_d;
    logic        write_finish_q, write_finish_d;
    logic        e_done_q, e_done_d;
    logic [31:0] e_rdata_q, e_rdata_d;
    logic        bus_err_q, bus_err_d;

    // Fixed-priority pick among the CPU channels: store, then load, then fetch.
    logic        cpu_any;
    logic [1:0]  cpu_id;
    logic        cpu_we, cpu_w, cpu_hw;
    logic [31:0] cpu_adr, cpu_wdata;
    logic        grant_ext;

    always_comb begin
        cpu_any   = i_read_req | d_read_req | d_write_req;
        cpu_id    = ID_IREAD;
        cpu_we    = 1'b0;
        cpu_w     = i_read_w;
        cpu_hw    = i_read_hw;
        cpu_adr   = i_read_adr;
        cpu_wdata = 32'h0;
        if (d_write_req) begin
            cpu_id    = ID_DWRITE;
            cpu_we    = 1'b1;
            cpu_w     = d_write_w;
            cpu_hw    = d_write_hw;
            cpu_adr   = d_write_adr;
            cpu_wdata = d_write_data;
        end else if (d_read_req) begin
            cpu_id  = ID_DREAD;
            cpu_w   = d_read_w;
            cpu_hw  = d_read_hw;
            cpu_adr = d_read_adr;
        end
        // On a CPU/external tie the side that did not win last time goes first.
        grant_ext = e_req & (~cpu_any | ~last_ext_q);
    end

    logic        finish;
    logic [31:0] fin_data;
    logic        fin_err;

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        last_ext_d     = last_ext_q;
        cnt_d          = cnt_q;
        m_req_d        = 1'b0;
        m_we_d         = m_we_q;
        m_adr_d        = m_adr_q;
        m_wdata_d      = m_wdata_q;
        m_be_d         = m_be_q;
        read_valid_d   = 1'b0;
        read_data_d    = read_data_q;
        write_finish_d = 1'b0;
        e_done_d       = 1'b0;
        e_rdata_d      = e_rdata_q;
        bus_err_d      = 1'b0;
        finish         = 1'b0;
        fin_data       = 32'h0;
        fin_err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_any || e_req) begin
                    state_d    = S_ISSUE;
                    m_req_d    = 1'b1;
                    last_ext_d = grant_ext;
                    if (grant_ext) begin
                        id_d      = ID_EXT;
                        m_we_d    = e_we;
                        m_adr_d   = e_adr;
                        m_wdata_d = e_wdata;
                        m_be_d    = byte_en(e_w, e_hw, e_adr[1:0]);
                    end else begin
                        id_d      = cpu_id;
                        m_we_d    = cpu_we;
                        m_adr_d   = cpu_adr;
                        m_wdata_d = cpu_wdata;
                        m_be_d    = byte_en(cpu_w, cpu_hw, cpu_adr[1:0]);
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = 16'h0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack in the same cycle as the timeout wins, so it is tested first.
                if (m_ack) begin
                    finish   = 1'b1;
                    fin_data = m_rdata;
                end else if (TIMEOUT != 0 && cnt_q == TIMEOUT_CNT) begin
                    finish   = 1'b1;
                    fin_data = 32'hFFFF_FFFF;
                    fin_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Completion outputs are loaded on entry to DONE so they are high during DONE.
        if (finish) begin
            state_d   = S_DONE;
            bus_err_d = fin_err;
            case (id_q)
                ID_IREAD, ID_DREAD: begin
                    read_valid_d = 1'b1;
                    read_data_d  = fin_data;
                end
                ID_DWRITE: begin
                    write_finish_d = 1'b1;
                end
                default: begin
                    e_done_d = 1'b1;
                    if (!m_we_q) begin
                        e_rdata_d = fin_data;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            id_q           <= ID_IREAD;
            last_ext_q     <= 1'b1;
            cnt_q          <= 16'h0;
            m_req_q        <= 1'b0;
            m_we_q         <= 1'b0;
            m_adr_q        <= 32'h0;
            m_wdata_q      <= 32'h0;
            m_be_q         <= 4'h0;
            read_valid_q   <= 1'b0;
            read_data_q    <= 32'h0;
            write_finish_q <= 1'b0;
            e_done_q       <= 1'b0;
            e_rdata_q      <= 32'h0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            last_ext_q     <= last_ext_d;
            cnt_q          <= cnt_d;
            m_req_q        <= m_req_d;
            m_we_q         <= m_we_d;
            m_adr_q        <= m_adr_d;
            m_wdata_q      <= m_wdata_d;
            m_be_q         <= m_be_d;
            read_valid_q   <= read_valid_d;
            read_data_q    <= read_data_d;
            write_finish_q <= write_finish_d;
            e_done_q       <= e_done_d;
            e_rdata_q      <= e_rdata_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign m_req        = m_req_q;
    assign m_we         = m_we_q;
    assign m_adr        = m_adr_q;
    assign m_wdata      = m_wdata_q;
    assign m_be         = m_be_q;
    assign read_valid   = read_valid_q;
    assign read_data    = read_data_q;
    assign write_finish = write_finish_q;
    assign e_done       = e_done_q;
    assign e_rdata      = e_rdata_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read_req, i_read_w, i_read_hw;
    logic [31:0] i_read_adr;
    logic        d_read_req, d_read_w, d_read_hw;
    logic [31:0] d_read_adr;
    logic        d_write_req, d_write_w, d_write_hw;
    logic [31:0] d_write_adr, d_write_data;
    logic        read_valid, write_finish;
    logic [31:0] read_data;
    logic        e_req, e_we, e_w, e_hw;
    logic [31:0] e_adr, e_wdata;
    logic        e_done, bus_err;
    logic [31:0] e_rdata;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_adr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
        .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
        .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
        .d_write_adr(d_write_adr), .d_write_data(d_write_data),
        .read_valid(read_valid), .read_data(read_data), .write_finish(write_finish),
        .e_req(e_req), .e_we(e_we), .e_w(e_w), .e_hw(e_hw), .e_adr(e_adr), .e_wdata(e_wdata),
        .e_done(e_done), .e_rdata(e_rdata), .bus_err(bus_err),
        .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    wire [137:0] all_out = {m_req, m_we, m_adr, m_wdata, m_be, read_valid, read_data,
                            write_finish, e_done, e_rdata, bus_err};

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef struct {
        int          kind;   // 0 CPU read, 1 CPU write, 2 external
        logic [31:0] data;
        bit          chk;
        logic        err;
    } cpl_t;

    cmd_t        cmd_q[$];
    cpl_t        cpl_q[$];
    logic [31:0] mem_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ack_delay = 2;
    int stray_req = 0;
    int stray_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic memory_model();
        int          ack_cnt = 0;
        logic [31:0] ack_data = 32'h0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if (rst_n === 1'b0) ack_cnt = 0;
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                m_ack      = 1'b1;
                m_rdata    = 32'hBAD0_BAD0;
            end
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    m_ack   = 1'b1;
                    m_rdata = ack_data;
                end
            end
            if (m_req === 1'b1 && rst_n === 1'b1) begin
                ack_data = 32'h0;
                if (m_we === 1'b0 && mem_q.size() > 0) ack_data = mem_q.pop_front();
                if (ack_delay > 0) ack_cnt = ack_delay;
            end
        end
    endtask

    task automatic scoreboard_monitor();
        cmd_t        c;
        cpl_t        e;
        int          np, kind;
        logic [31:0] dgot;
        forever begin
            @(negedge clk);
            if (m_req === 1'b1) begin
                tests++;
                if (cmd_q.size() == 0) begin
                    fails++;
                    $display("FAIL cmd: unexpected m_req adr=%h, required none", m_adr);
                end else begin
                    c = cmd_q.pop_front();
                    if (m_we !== c.we || m_adr !== c.adr || m_be !== c.be || (c.we && m_wdata !== c.wdata)) begin
                        fails++;
                        $display("FAIL cmd: got we=%b adr=%h be=%b wdata=%h, required we=%b adr=%h be=%b wdata=%h",
                                 m_we, m_adr, m_be, m_wdata, c.we, c.adr, c.be, c.wdata);
                    end
                end
            end
            np = (read_valid === 1'b1 ? 1 : 0) + (write_finish === 1'b1 ? 1 : 0) + (e_done === 1'b1 ? 1 : 0);
            if (np > 0 || bus_err === 1'b1) begin
                tests++;
                if (cpl_q.size() == 0 || np != 1) begin
                    fails++;
                    $display("FAIL cpl: unexpected pulses rv=%b wf=%b ed=%b err=%b, required none",
                             read_valid, write_finish, e_done, bus_err);
                end else begin
                    e    = cpl_q.pop_front();
                    kind = read_valid === 1'b1 ? 0 : (write_finish === 1'b1 ? 1 : 2);
                    dgot = kind == 0 ? read_data : e_rdata;
                    if (kind != e.kind || bus_err !== e.err || (e.chk && dgot !== e.data)) begin
                        fails++;
                        $display("FAIL cpl: got kind=%0d data=%h err=%b, required kind=%0d data=%h err=%b",
                                 kind, dgot, bus_err, e.kind, e.data, e.err);
                    end
                end
            end
        end
    endtask

    // Drives one requester, holds it until its completion, drops it in the DONE cycle.
    task automatic access(input int ch, input logic w, input logic hw, input logic [31:0] adr,
                          input logic [31:0] data, output int t0, output int t_req, output int t_cpl);
        t_req = -1;
        t_cpl = -1;
        @(negedge clk);
        t0 = cyc;
        case (ch)
            0: begin i_read_req = 1; i_read_w = w; i_read_hw = hw; i_read_adr = adr; end
            1: begin d_read_req = 1; d_read_w = w; d_read_hw = hw; d_read_adr = adr; end
            2: begin d_write_req = 1; d_write_w = w; d_write_hw = hw; d_write_adr = adr; d_write_data = data; end
            default: begin e_req = 1; e_we = (ch == 4); e_w = w; e_hw = hw; e_adr = adr; e_wdata = data; end
        endcase
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (m_req === 1'b1 && t_req < 0) t_req = cyc;
            if (read_valid === 1'b1 || write_finish === 1'b1 || e_done === 1'b1) begin
                t_cpl = cyc;
                break;
            end
        end
        i_read_req = 0; d_read_req = 0; d_write_req = 0; e_req = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (all_out !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word_read();
        int t0, tr, tc;
        ack_delay = 2;
        mem_q.push_back(32'hDEAD_BEEF);
        cmd_q.push_back('{we: 1'b0, adr: 32'h100, wdata: 32'h0, be: 4'b1111});
        cpl_q.push_back('{kind: 0, data: 32'hDEAD_BEEF, chk: 1'b1, err: 1'b0});
        access(1, 1'b1, 1'b0, 32'h100, 32'h0, t0, tr, tc);
        tests++;
        if (tr - t0 != 1 || tc - t0 != 4) begin
            fails++;
            $display("FAIL word_read_timing: m_req at %0d, read_valid at %0d, required 1 and 4", tr - t0, tc - t0);
        end
    endtask

    task automatic test_halfword_write();
        int t0, tr, tc;
        ack_delay = 2;
        cmd_q.push_back('{we: 1'b1, adr: 32'h202, wdata: 32'h1234_0000, be: 4'b1100});
        cpl_q.push_back('{kind: 1, data: 32'h0, chk: 1'b0, err: 1'b0});
        access(2, 1'b0, 1'b1, 32'h202, 32'h1234_0000, t0, tr, tc);
        tests++;
        if (tc - tr != 3) begin
            fails++;
            $display("FAIL hw_write_timing: completion %0d cycles after m_req, required 3", tc - tr);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_byte_enables();
        int          ch_t[5]  = '{4, 3, 0, 1, 2};
        logic [1:0]  sz_t[5]  = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        logic [31:0] adr_t[5] = '{32'h303, 32'h10, 32'h401, 32'h2, 32'h0};
        logic [31:0] dat_t[5] = '{32'h5500_0000, 32'hCAFE_F00D, 32'h0000_AB00, 32'h1357_0000, 32'h0000_0042};
        logic [3:0]  be_t[5]  = '{4'b1000, 4'b0011, 4'b0010, 4'b1100, 4'b0001};
        int          t0, tr, tc, kind;
        bit          rd;
        ack_delay = 2;
        for (int i = 0; i < 5; i++) begin
            rd   = (ch_t[i] == 0 || ch_t[i] == 1 || ch_t[i] == 3);
            kind = ch_t[i] <= 1 ? 0 : (ch_t[i] == 2 ? 1 : 2);
            if (rd) mem_q.push_back(dat_t[i]);
            cmd_q.push_back('{we: !rd, adr: adr_t[i], wdata: dat_t[i], be: be_t[i]});
            cpl_q.push_back('{kind: kind, data: dat_t[i], chk: rd, err: 1'b0});
            access(ch_t[i], sz_t[i][1], sz_t[i][0], adr_t[i], dat_t[i], t0, tr, tc);
            tests++;
            if (tc - t0 != 4) begin
                fails++;
                $display("FAIL byte_en_access%0d: completion at %0d, required 4", i, tc - t0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, tr1, tr2, tc;
        ack_delay = 1;
        for (int i = 0; i < 2; i++) begin
            mem_q.push_back(32'h0A0B_0C00 + i);
            cmd_q.push_back('{we: 1'b0, adr: 32'h800 + 4 * i, wdata: 32'h0, be: 4'b1111});
            cpl_q.push_back('{kind: 0, data: 32'h0A0B_0C00 + i, chk: 1'b1, err: 1'b0});
        end
        access(1, 1'b1, 1'b0, 32'h800, 32'h0, t0, tr1, tc);
        access(1, 1'b1, 1'b0, 32'h804, 32'h0, t0, tr2, tc);
        tests++;
        if (tr2 - tr1 != 4) begin
            fails++;
            $display("FAIL back_to_back: m_req spacing %0d, required 4", tr2 - tr1);
        end
    endtask

    task automatic test_round_robin();
        int n_cpu, n_ext;
        bit raise;
        ack_delay = 2;
        for (int off = 0; off < 3; off++) begin
            @(negedge clk); rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            repeat (off) @(negedge clk);
            mem_q.push_back(32'h1000 + off); mem_q.push_back(32'h2000 + off); mem_q.push_back(32'h3000 + off);
            cmd_q.push_back('{we: 1'b0, adr: 32'h500 + 16 * off, wdata: 32'h0, be: 4'b1111});
            cmd_q.push_back('{we: 1'b0, adr: 32'hE00 + 16 * off, wdata: 32'h0, be: 4'b1111});
            cmd_q.push_back('{we: 1'b0, adr: 32'h504 + 16 * off, wdata: 32'h0, be: 4'b1111});
            cpl_q.push_back('{kind: 0, data: 32'h1000 + off, chk: 1'b1, err: 1'b0});
            cpl_q.push_back('{kind: 2, data: 32'h2000 + off, chk: 1'b1, err: 1'b0});
            cpl_q.push_back('{kind: 0, data: 32'h3000 + off, chk: 1'b1, err: 1'b0});
            i_read_req = 1; i_read_w = 1; i_read_hw = 0; i_read_adr = 32'h500 + 16 * off;
            e_req = 1; e_we = 0; e_w = 1; e_hw = 0; e_adr = 32'hE00 + 16 * off;
            n_cpu = 0; n_ext = 0; raise = 0;
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                if (raise) begin
                    i_read_req = 1; i_read_adr = 32'h504 + 16 * off; raise = 0;
                end
                if (read_valid === 1'b1) begin
                    n_cpu++; i_read_req = 0;
                    if (n_cpu == 1) raise = 1;
                end
                if (e_done === 1'b1) begin
                    n_ext++; e_req = 0;
                end
                if (n_cpu == 2 && n_ext == 1) break;
            end
            i_read_req = 0; e_req = 0;
            tests++;
            if (n_cpu != 2 || n_ext != 1) begin
                fails++;
                $display("FAIL round_robin_off%0d: cpu=%0d ext=%0d completions, required 2 and 1", off, n_cpu, n_ext);
            end
        end
    endtask

    task automatic test_priority();
        int n_wr = 0, n_rd = 0;
        ack_delay = 2;
        mem_q.push_back(32'h1111_1111); mem_q.push_back(32'h2222_2222);
        cmd_q.push_back('{we: 1'b1, adr: 32'h600, wdata: 32'hA5A5_A5A5, be: 4'b1111});
        cmd_q.push_back('{we: 1'b0, adr: 32'h604, wdata: 32'h0, be: 4'b1111});
        cmd_q.push_back('{we: 1'b0, adr: 32'h608, wdata: 32'h0, be: 4'b1111});
        cpl_q.push_back('{kind: 1, data: 32'h0, chk: 1'b0, err: 1'b0});
        cpl_q.push_back('{kind: 0, data: 32'h1111_1111, chk: 1'b1, err: 1'b0});
        cpl_q.push_back('{kind: 0, data: 32'h2222_2222, chk: 1'b1, err: 1'b0});
        @(negedge clk);
        d_write_req = 1; d_write_w = 1; d_write_hw = 0; d_write_adr = 32'h600; d_write_data = 32'hA5A5_A5A5;
        d_read_req = 1; d_read_w = 1; d_read_hw = 0; d_read_adr = 32'h604;
        i_read_req = 1; i_read_w = 1; i_read_hw = 0; i_read_adr = 32'h608;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (write_finish === 1'b1) begin n_wr++; d_write_req = 0; end
            if (read_valid === 1'b1) begin
                n_rd++;
                if (n_rd == 1) d_read_req = 0; else i_read_req = 0;
            end
            if (n_wr == 1 && n_rd == 2) break;
        end
        d_write_req = 0; d_read_req = 0; i_read_req = 0;
        tests++;
        if (n_wr != 1 || n_rd != 2) begin
            fails++;
            $display("FAIL priority: writes=%0d reads=%0d, required 1 and 2", n_wr, n_rd);
        end
    endtask

    task automatic test_timeout();
        int t0, tr, tc, np;
        ack_delay = 0;
        cmd_q.push_back('{we: 1'b0, adr: 32'h900, wdata: 32'h0, be: 4'b1111});
        cpl_q.push_back('{kind: 0, data: 32'hFFFF_FFFF, chk: 1'b1, err: 1'b1});
        access(1, 1'b1, 1'b0, 32'h900, 32'h0, t0, tr, tc);
        stray_req++;
        tests++;
        if (tc - tr != TO + 2) begin
            fails++;
            $display("FAIL timeout_latency: completion %0d cycles after m_req, required %0d", tc - tr, TO + 2);
        end
        np = 0;
        repeat (6) begin
            @(negedge clk);
            if (read_valid === 1'b1 || bus_err === 1'b1 || m_req === 1'b1) np++;
        end
        tests++;
        if (np != 0) begin
            fails++;
            $display("FAIL late_ack: %0d pulses after timeout, required 0", np);
        end
        // Ack landing exactly on the timeout cycle must win with no error.
        ack_delay = TO + 1;
        mem_q.push_back(32'h600D_F00D);
        cmd_q.push_back('{we: 1'b0, adr: 32'h904, wdata: 32'h0, be: 4'b1111});
        cpl_q.push_back('{kind: 0, data: 32'h600D_F00D, chk: 1'b1, err: 1'b0});
        access(1, 1'b1, 1'b0, 32'h904, 32'h0, t0, tr, tc);
        tests++;
        if (tc - tr != TO + 2) begin
            fails++;
            $display("FAIL ack_at_timeout: completion %0d cycles after m_req, required %0d", tc - tr, TO + 2);
        end
    endtask

    task automatic test_reset_in_wait();
        int t0, tr, tc, np;
        bit seen = 0;
        ack_delay = 0;
        cmd_q.push_back('{we: 1'b0, adr: 32'h700, wdata: 32'h0, be: 4'b1111});
        @(negedge clk);
        d_read_req = 1; d_read_w = 1; d_read_hw = 0; d_read_adr = 32'h700;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m_req === 1'b1) begin seen = 1; break; end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0; d_read_req = 0;
        @(negedge clk);
        tests++;
        if (all_out !== '0 || !seen) begin
            fails++;
            $display("FAIL reset_in_wait: outputs %h issued=%0d, required 0 and 1", all_out, seen);
        end
        rst_n = 1'b1;
        stray_req++;
        np = 0;
        repeat (8) begin
            @(negedge clk);
            if (read_valid === 1'b1 || write_finish === 1'b1 || e_done === 1'b1 || bus_err === 1'b1 || m_req === 1'b1) np++;
        end
        tests++;
        if (np != 0) begin
            fails++;
            $display("FAIL reset_abandon: %0d pulses after reset, required 0", np);
        end
        ack_delay = 2;
        mem_q.push_back(32'h7777_0001);
        cmd_q.push_back('{we: 1'b0, adr: 32'h710, wdata: 32'h0, be: 4'b1111});
        cpl_q.push_back('{kind: 0, data: 32'h7777_0001, chk: 1'b1, err: 1'b0});
        access(1, 1'b1, 1'b0, 32'h710, 32'h0, t0, tr, tc);
        tests++;
        if (tc - t0 != 4) begin
            fails++;
            $display("FAIL after_reset_access: completion at %0d, required 4", tc - t0);
        end
    endtask

    initial begin
        rst_n = 0;
        i_read_req = 0; i_read_w = 0; i_read_hw = 0; i_read_adr = 0;
        d_read_req = 0; d_read_w = 0; d_read_hw = 0; d_read_adr = 0;
        d_write_req = 0; d_write_w = 0; d_write_hw = 0; d_write_adr = 0; d_write_data = 0;
        e_req = 0; e_we = 0; e_w = 0; e_hw = 0; e_adr = 0; e_wdata = 0;
        m_ack = 0; m_rdata = 0;
        fork
            memory_model();
            scoreboard_monitor();
        join_none
        test_reset();
        test_word_read();
        test_halfword_write();
        test_byte_enables();
        test_back_to_back();
        test_round_robin();
        test_priority();
        test_timeout();
        test_reset_in_wait();
        repeat (3) @(negedge clk);
        tests++;
        if (cmd_q.size() != 0 || cpl_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d commands, %0d completions left, required 0 and 0",
                     cmd_q.size(), cpl_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
